// File: rtl/st7735_spi_sink.sv
// ST7735 4-wire SPI receiver: oversamples the link in the clk domain, assembles bytes and
// decodes CASET/RASET/RAMWR into a stream of (x, y, color) pixel strobes.
module st7735_spi_sink #(
    parameter int C_x_bits      = 7,
    parameter int C_y_bits      = 8,
    parameter int C_width       = 128,
    parameter int C_height      = 160,
    parameter int C_color_bits  = 16,
    parameter int C_sync_stages = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    spi_csn,
    input  logic                    spi_clk,
    input  logic                    spi_mosi,
    input  logic                    spi_dc,
    input  logic                    spi_resn,
    output logic                    byte_valid,
    output logic [7:0]              byte_data,
    output logic                    byte_dc,
    output logic                    pixel_valid,
    output logic [C_x_bits-1:0]     x,
    output logic [C_y_bits-1:0]     y,
    output logic [C_color_bits-1:0] color
);

    localparam logic [C_x_bits-1:0] XE_DEFAULT = C_x_bits'(C_width - 1);
    localparam logic [C_y_bits-1:0] YE_DEFAULT = C_y_bits'(C_height - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CASET = 2'd1,
        ST_RASET = 2'd2,
        ST_RAMWR = 2'd3
    } state_t;

    logic [C_sync_stages-1:0] csn_sync_r;
    logic [C_sync_stages-1:0] sclk_sync_r;
    logic [C_sync_stages-1:0] mosi_sync_r;
    logic [C_sync_stages-1:0] dc_sync_r;
    logic [C_sync_stages-1:0] resn_sync_r;
    logic                     sclk_prev_r;
    logic                     csn_s;
    logic                     sclk_s;
    logic                     mosi_s;
    logic                     dc_s;
    logic                     resn_s;
    logic                     sclk_rise_s;

    logic [2:0]               bit_cnt_r;
    logic [6:0]               shift_r;

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic [1:0]               param_cnt_r;
    logic [15:0]              start_word_r;
    logic [7:0]               end_hi_r;
    logic [15:0]              end_word_s;
    logic [C_x_bits-1:0]      xs_r;
    logic [C_x_bits-1:0]      xe_r;
    logic [C_y_bits-1:0]      ys_r;
    logic [C_y_bits-1:0]      ye_r;
    logic [C_x_bits-1:0]      ptr_x_r;
    logic [C_y_bits-1:0]      ptr_y_r;
    logic                     pending_r;
    logic [7:0]               color_hi_r;

    assign csn_s       = csn_sync_r[C_sync_stages-1];
    assign sclk_s      = sclk_sync_r[C_sync_stages-1];
    assign mosi_s      = mosi_sync_r[C_sync_stages-1];
    assign dc_s        = dc_sync_r[C_sync_stages-1];
    assign resn_s      = resn_sync_r[C_sync_stages-1];
    assign sclk_rise_s = sclk_s & ~sclk_prev_r;
    assign end_word_s  = {end_hi_r, byte_data};

    // Synchronizer chains for the asynchronous SPI pins plus SCLK edge history.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            csn_sync_r  <= '1;
            sclk_sync_r <= '0;
            mosi_sync_r <= '0;
            dc_sync_r   <= '0;
            resn_sync_r <= '1;
            sclk_prev_r <= 1'b0;
        end else begin
            csn_sync_r  <= {csn_sync_r[C_sync_stages-2:0], spi_csn};
            sclk_sync_r <= {sclk_sync_r[C_sync_stages-2:0], spi_clk};
            mosi_sync_r <= {mosi_sync_r[C_sync_stages-2:0], spi_mosi};
            dc_sync_r   <= {dc_sync_r[C_sync_stages-2:0], spi_dc};
            resn_sync_r <= {resn_sync_r[C_sync_stages-2:0], spi_resn};
            sclk_prev_r <= sclk_s;
        end
    end

    // MSB-first byte shifter; CSN high throws away any partial byte.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bit_cnt_r  <= 3'd0;
            shift_r    <= 7'd0;
            byte_valid <= 1'b0;
            byte_data  <= 8'd0;
            byte_dc    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (csn_s) begin
                bit_cnt_r <= 3'd0;
            end else if (sclk_rise_s) begin
                shift_r   <= {shift_r[5:0], mosi_s};
                bit_cnt_r <= bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd7) begin
                    byte_data  <= {shift_r, mosi_s};
                    byte_dc    <= dc_s;
                    byte_valid <= 1'b1;
                end
            end
        end
    end

    // Decoder state register; the display reset pin returns it to IDLE.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else if (!resn_s) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: any command byte re-decodes; window commands end after 4 parameters.
    always_comb begin
        state_nxt_s = state_r;
        if (byte_valid) begin
            if (!byte_dc) begin
                case (byte_data)
                    8'h2A:   state_nxt_s = ST_CASET;
                    8'h2B:   state_nxt_s = ST_RASET;
                    8'h2C:   state_nxt_s = ST_RAMWR;
                    default: state_nxt_s = ST_IDLE;
                endcase
            end else begin
                case (state_r)
                    ST_CASET,
                    ST_RASET: begin
                        if (param_cnt_r == 2'd3) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = state_r;
                        end
                    end
                    default: state_nxt_s = state_r;
                endcase
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Window shadow/commit, write pointer and pixel assembly.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            param_cnt_r  <= 2'd0;
            start_word_r <= 16'd0;
            end_hi_r     <= 8'd0;
            xs_r         <= '0;
            xe_r         <= XE_DEFAULT;
            ys_r         <= '0;
            ye_r         <= YE_DEFAULT;
            ptr_x_r      <= '0;
            ptr_y_r      <= '0;
            pending_r    <= 1'b0;
            color_hi_r   <= 8'd0;
            pixel_valid  <= 1'b0;
            x            <= '0;
            y            <= '0;
            color        <= '0;
        end else begin
            pixel_valid <= 1'b0;
            if (!resn_s) begin
                param_cnt_r <= 2'd0;
                xs_r        <= '0;
                xe_r        <= XE_DEFAULT;
                ys_r        <= '0;
                ye_r        <= YE_DEFAULT;
                ptr_x_r     <= '0;
                ptr_y_r     <= '0;
                pending_r   <= 1'b0;
            end else if (byte_valid) begin
                if (!byte_dc) begin
                    // A command drops any half-received pixel.
                    pending_r   <= 1'b0;
                    param_cnt_r <= 2'd0;
                    if (byte_data == 8'h2C) begin
                        ptr_x_r <= xs_r;
                        ptr_y_r <= ys_r;
                    end
                end else begin
                    case (state_r)
                        ST_CASET,
                        ST_RASET: begin
                            param_cnt_r <= param_cnt_r + 2'd1;
                            case (param_cnt_r)
                                2'd0: start_word_r[15:8] <= byte_data;
                                2'd1: start_word_r[7:0]  <= byte_data;
                                2'd2: end_hi_r           <= byte_data;
                                default: begin
                                    if (state_r == ST_CASET) begin
                                        xs_r <= C_x_bits'(start_word_r);
                                        xe_r <= C_x_bits'(end_word_s);
                                    end else begin
                                        ys_r <= C_y_bits'(start_word_r);
                                        ye_r <= C_y_bits'(end_word_s);
                                    end
                                end
                            endcase
                        end
                        ST_RAMWR: begin
                            if (!pending_r) begin
                                color_hi_r <= byte_data;
                                pending_r  <= 1'b1;
                            end else begin
                                pending_r   <= 1'b0;
                                pixel_valid <= 1'b1;
                                x           <= ptr_x_r;
                                y           <= ptr_y_r;
                                color       <= C_color_bits'({color_hi_r, byte_data});
                            end
                        end
                        default: ;
                    endcase
                end
            end else if (pixel_valid) begin
                if (ptr_x_r == xe_r) begin
                    ptr_x_r <= xs_r;
                    if (ptr_y_r == ye_r) begin
                        ptr_y_r <= ys_r;
                    end else begin
                        ptr_y_r <= ptr_y_r + C_y_bits'(1);
                    end
                end else begin
                    ptr_x_r <= ptr_x_r + C_x_bits'(1);
                end
            end
        end
    end

endmodule
